// File: rtl/pcie_lane_gate.sv
// pcie_lane_gate: per-lane gating of PCIe serial pairs with a synchronised, settle-timed connect sequencer.
// Define PCIE_LANE_GATE_STATS_EN to add the reconfig_count / abort_count statistics outputs.
//
// state  | meaning
// IDLE   | lane_active matches the synchronised request; nothing pending
// SETTLE | request changed; removed lanes already gated, added lanes wait out the quiet period
module pcie_lane_gate #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] rxp_in,
    input  logic [WIDTH-1:0] rxn_in,
    input  logic [WIDTH-1:0] txp_in,
    input  logic [WIDTH-1:0] txn_in,
    output logic [WIDTH-1:0] rxp_out,
    output logic [WIDTH-1:0] rxn_out,
    output logic [WIDTH-1:0] txp_out,
    output logic [WIDTH-1:0] txn_out,
    output logic [WIDTH-1:0] lane_active,
`ifdef PCIE_LANE_GATE_STATS_EN
    output logic [15:0]      reconfig_count,
    output logic [7:0]       abort_count,
`endif
    output logic             busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] en_meta;
    logic [WIDTH-1:0] en_s;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] target_nxt;
    logic [WIDTH-1:0] lane_active_nxt;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_nxt;

    // en is asynchronous to CLK; only the second stage is ever looked at.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            en_meta <= '0;
            en_s    <= '0;
        end else begin
            en_meta <= en;
            en_s    <= en_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            target      <= '0;
            counter     <= '0;
            lane_active <= '0;
        end else begin
            state       <= state_nxt;
            target      <= target_nxt;
            counter     <= counter_nxt;
            lane_active <= lane_active_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        target_nxt      = target;
        counter_nxt     = counter;
        lane_active_nxt = lane_active;
        case (state)
            IDLE: begin
                if (en_s != lane_active) begin
                    target_nxt      = en_s;
                    counter_nxt     = RELOAD;
                    lane_active_nxt = lane_active & en_s;
                    state_nxt       = SETTLE;
                end
            end
            SETTLE: begin
                // A changed request restarts the quiet period, but removals still drop right away.
                if (en_s != target) begin
                    target_nxt      = en_s;
                    counter_nxt     = RELOAD;
                    lane_active_nxt = lane_active & en_s;
                end else if (counter == '0) begin
                    lane_active_nxt = target;
                    state_nxt       = IDLE;
                end else begin
                    counter_nxt = counter - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // 0/0 on a gated pair models electrical idle on both legs.
    always_comb begin
        rxp_out = rxp_in & lane_active;
        rxn_out = rxn_in & lane_active;
        txp_out = txp_in & lane_active;
        txn_out = txn_in & lane_active;
        busy    = (state == SETTLE);
    end

`ifdef PCIE_LANE_GATE_STATS_EN
    logic commit;
    logic restart;

    assign restart = (state == SETTLE) && (en_s != target);
    assign commit  = (state == SETTLE) && (en_s == target) && (counter == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reconfig_count <= '0;
            abort_count    <= '0;
        end else begin
            if (commit && (reconfig_count != 16'hFFFF)) begin
                reconfig_count <= reconfig_count + 16'd1;
            end
            if (restart && (abort_count != 8'hFF)) begin
                abort_count <= abort_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcie_lane_gate.sv
// Bench for pcie_lane_gate: table-driven request changes, hand-built restart/reset sequences,
// then randomized requests compared against a deadline-based behavioural model.
module tb_pcie_lane_gate;

    localparam int W = 8;
    localparam int S = 16;

    logic         CLK    = 1'b0;
    logic         RST_N  = 1'b0;
    logic [W-1:0] en     = '0;
    logic [W-1:0] rxp_in = '0;
    logic [W-1:0] rxn_in = '0;
    logic [W-1:0] txp_in = '0;
    logic [W-1:0] txn_in = '0;
    logic [W-1:0] rxp_out, rxn_out, txp_out, txn_out, lane_active;
    logic         busy;
`ifdef PCIE_LANE_GATE_STATS_EN
    logic [15:0]  reconfig_count;
    logic [7:0]   abort_count;
`endif

    pcie_lane_gate #(.WIDTH(W), .SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .en(en),
        .rxp_in(rxp_in), .rxn_in(rxn_in), .txp_in(txp_in), .txn_in(txn_in),
        .rxp_out(rxp_out), .rxn_out(rxn_out), .txp_out(txp_out), .txn_out(txn_out),
        .lane_active(lane_active),
`ifdef PCIE_LANE_GATE_STATS_EN
        .reconfig_count(reconfig_count), .abort_count(abort_count),
`endif
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Gated pairs must pass data only on lanes expected to be connected.
    task automatic dp_check(input string tag, input logic [W-1:0] act);
        rxp_in = '1; rxn_in = '1; txp_in = '1; txn_in = '1;
        #1;
        chk({tag, "_rxp1"}, 16'(rxp_out), 16'(act));
        chk({tag, "_rxn1"}, 16'(rxn_out), 16'(act));
        chk({tag, "_txp1"}, 16'(txp_out), 16'(act));
        chk({tag, "_txn1"}, 16'(txn_out), 16'(act));
        rxp_in = W'($urandom); rxn_in = W'($urandom);
        txp_in = W'($urandom); txn_in = W'($urandom);
        #1;
        chk({tag, "_rxp"}, 16'(rxp_out), 16'(rxp_in & act));
        chk({tag, "_rxn"}, 16'(rxn_out), 16'(rxn_in & act));
        chk({tag, "_txp"}, 16'(txp_out), 16'(txp_in & act));
        chk({tag, "_txn"}, 16'(txn_out), 16'(txn_in & act));
    endtask

    // Reference model: a request seen two edges late; additions commit at a deadline edge.
    logic [W-1:0] m_act, m_tgt, m_req;
    logic [W-1:0] m_pipe[$];
    bit           m_busy;
    longint       m_edge, m_due;
    int           m_commits, m_restarts;

    task automatic model_step();
        if (!RST_N) begin
            m_act = '0; m_tgt = '0; m_busy = 1'b0;
            m_edge = 0; m_due = 0; m_pipe = {W'(0), W'(0)};
            m_commits = 0; m_restarts = 0;
        end else begin
            m_edge++;
            m_req = m_pipe.pop_front();
            m_pipe.push_back(en);
            if ((m_busy && m_req != m_tgt) || (!m_busy && m_req != m_act)) begin
                if (m_busy && m_restarts < 255) m_restarts++;
                m_tgt  = m_req;
                m_act  = m_act & m_req;
                m_busy = 1'b1;
                m_due  = m_edge + S;
            end else if (m_busy && m_edge == m_due) begin
                m_act  = m_tgt;
                m_busy = 1'b0;
                if (m_commits < 65535) m_commits++;
            end
        end
    endtask

    always @(posedge CLK or negedge RST_N) model_step();

    typedef struct {
        logic [W-1:0] req;
        logic [W-1:0] act_e3;
        logic [W-1:0] act_e19;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [W-1:0] prev;
        tbl[0] = '{req: 8'hFF, act_e3: 8'h00, act_e19: 8'hFF};
        tbl[1] = '{req: 8'h0F, act_e3: 8'h0F, act_e19: 8'h0F};
        tbl[2] = '{req: 8'hF0, act_e3: 8'h00, act_e19: 8'hF0};
        tbl[3] = '{req: 8'h00, act_e3: 8'h00, act_e19: 8'h00};
        tbl[4] = '{req: 8'h3C, act_e3: 8'h00, act_e19: 8'h3C};
        tbl[5] = '{req: 8'h5A, act_e3: 8'h18, act_e19: 8'h5A};

        step(3);
        chk("rst_act", 16'(lane_active), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        dp_check("rst", '0);

        RST_N = 1'b1;
        prev  = '0;
        foreach (tbl[i]) begin
            en = tbl[i].req;
            step(2);
            chk($sformatf("v%0d_e2_act", i), 16'(lane_active), 16'(prev));
            chk($sformatf("v%0d_e2_busy", i), 16'(busy), 16'h0);
            step(1);
            chk($sformatf("v%0d_e3_act", i), 16'(lane_active), 16'(tbl[i].act_e3));
            chk($sformatf("v%0d_e3_busy", i), 16'(busy), 16'h1);
            dp_check($sformatf("v%0d_e3", i), tbl[i].act_e3);
            step(15);
            chk($sformatf("v%0d_e18_act", i), 16'(lane_active), 16'(tbl[i].act_e3));
            chk($sformatf("v%0d_e18_busy", i), 16'(busy), 16'h1);
            step(1);
            chk($sformatf("v%0d_e19_act", i), 16'(lane_active), 16'(tbl[i].act_e19));
            chk($sformatf("v%0d_e19_busy", i), 16'(busy), 16'h0);
            dp_check($sformatf("v%0d_e19", i), tbl[i].act_e19);
            prev = tbl[i].act_e19;
        end

        // Restart: a second request mid-settle must never expose the first one.
        en = 8'h00;
        step(19);
        chk("rs_base", 16'(lane_active), 16'h00);
        en = 8'h01;
        step(5);
        en = 8'h03;
        for (int k = 1; k <= 19; k++) begin
            step(1);
            chk($sformatf("rs_k%0d", k), 16'(lane_active), (k == 19) ? 16'h03 : 16'h00);
        end
        chk("rs_busy", 16'(busy), 16'h0);

        // Asynchronous reset mid-settle.
        en = 8'h0F;
        step(19);
        chk("ar_pre", 16'(lane_active), 16'h0F);
        en = 8'hFF;
        step(5);
        chk("ar_busy_pre", 16'(busy), 16'h1);
        chk("ar_act_pre", 16'(lane_active), 16'h0F);
        #2 RST_N = 1'b0;
        #1;
        chk("ar_act", 16'(lane_active), 16'h00);
        chk("ar_busy", 16'(busy), 16'h0);
        dp_check("ar", '0);
        step(1);
        RST_N = 1'b1;
        step(18);
        chk("ar_e18", 16'(lane_active), 16'h00);
        chk("ar_e18_busy", 16'(busy), 16'h1);
        step(1);
        chk("ar_e19", 16'(lane_active), 16'hFF);

        // Randomized requests, short holds included so additions get starved by restarts.
        for (int n = 0; n < 250; n++) begin
            int hold;
            en   = W'($urandom);
            hold = int'($urandom_range(1, 30));
            for (int c = 0; c < hold; c++) begin
                step(1);
                chk("rnd_act", 16'(lane_active), 16'(m_act));
                chk("rnd_busy", 16'(busy), 16'(m_busy));
                rxp_in = W'($urandom); rxn_in = W'($urandom);
                txp_in = W'($urandom); txn_in = W'($urandom);
                #1;
                chk("rnd_rxp", 16'(rxp_out), 16'(rxp_in & m_act));
                chk("rnd_txn", 16'(txn_out), 16'(txn_in & m_act));
`ifdef PCIE_LANE_GATE_STATS_EN
                chk("rnd_reconfig", reconfig_count, 16'(m_commits));
                chk("rnd_abort", 16'(abort_count), 16'(m_restarts));
`endif
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
